// File: rtl/dm_sba_arb.sv
// Round-robin arbiter sharing one system-bus host port between NumReq requesters, one transaction in flight.
// Optional response watchdog enabled by defining DM_SBA_ARB_TIMEOUT_EN.
module dm_sba_arb #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0]                    req_i,
    input  logic [NumReq-1:0][BusWidth-1:0]      addr_i,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq-1:0][BusWidth-1:0]      wdata_i,
    input  logic [NumReq-1:0][BusWidth/8-1:0]    be_i,
    output logic [NumReq-1:0]                    gnt_o,
    output logic [NumReq-1:0]                    r_valid_o,
    output logic [BusWidth-1:0]                  r_rdata_o,
    output logic                                 r_err_o,
    output logic                                 host_req_o,
    output logic [BusWidth-1:0]                  host_addr_o,
    output logic                                 host_we_o,
    output logic [BusWidth-1:0]                  host_wdata_o,
    output logic [BusWidth/8-1:0]                host_be_o,
    input  logic                                 host_gnt_i,
    input  logic                                 host_r_valid_i,
    input  logic [BusWidth-1:0]                  host_r_rdata_i,
    input  logic                                 host_r_err_i,
    output logic                                 timeout_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    if (NumReq < 2 || TimeoutCycles < 2) begin : g_param_check
        $error("dm_sba_arb: NumReq and TimeoutCycles must both be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e          state_q;
    logic [IdxW-1:0] ptr_q, owner_q;
    logic [IdxW-1:0] winner, owner;
    logic            found, presenting, resp_ok;
    logic            stale, abort;

    function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] cur);
        if (32'(cur) == NumReq - 1) return '0;
        return cur + IdxW'(1);
    endfunction

    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!found && req_i[IdxW'(idx)]) begin
                found  = 1'b1;
                winner = IdxW'(idx);
            end
        end
    end

    // The owner is the live winner while arbitrating, the locked owner afterwards.
    assign owner      = (state_q == StIdle) ? winner : owner_q;
    assign presenting = ((state_q == StIdle) && found && !stale) || (state_q == StReq);
    assign resp_ok    = (state_q == StResp) && host_r_valid_i;

    assign host_req_o   = presenting;
    assign host_addr_o  = addr_i[owner];
    assign host_we_o    = we_i[owner];
    assign host_wdata_o = wdata_i[owner];
    assign host_be_o    = be_i[owner];

    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        if (presenting) gnt_o[owner] = host_gnt_i;
        if (resp_ok || abort) r_valid_o[owner_q] = 1'b1;
    end

    assign r_rdata_o = resp_ok ? host_r_rdata_i : '0;
    assign r_err_o   = resp_ok ? host_r_err_i : abort;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (presenting) begin
                        owner_q <= winner;
                        if (host_gnt_i) begin
                            state_q <= StResp;
                            ptr_q   <= next_ptr(winner);
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (host_gnt_i) begin
                        state_q <= StResp;
                        ptr_q   <= next_ptr(owner_q);
                    end
                end
                StResp: begin
                    if (host_r_valid_i || abort) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DM_SBA_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_q;
    logic            stale_q, timeout_q;

    // A real response in the limit cycle wins over the abort.
    assign abort     = (state_q == StResp) && !host_r_valid_i && (cnt_q == CntW'(TimeoutCycles - 1));
    assign stale     = stale_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            stale_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == StResp) && !host_r_valid_i && !abort) cnt_q <= cnt_q + CntW'(1);
            else cnt_q <= '0;
            if (abort) begin
                stale_q   <= 1'b1;
                timeout_q <= 1'b1;
            end else if (stale_q && host_r_valid_i) begin
                stale_q <= 1'b0;
            end
        end
    end
`else
    assign abort     = 1'b0;
    assign stale     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    req_held_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StReq) |-> req_i[owner_q]);

endmodule

// File: tb/tb_dm_sba_arb.sv
// Directed bench for dm_sba_arb with a response scoreboard; timeout steps run when DM_SBA_ARB_TIMEOUT_EN is defined.
module tb_dm_sba_arb;
    localparam int unsigned NumReq = 2;
    localparam int unsigned BW     = 32;
    localparam int unsigned TC     = 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NumReq-1:0]            req, we;
    logic [NumReq-1:0][BW-1:0]    addr, wdata;
    logic [NumReq-1:0][BW/8-1:0]  be;
    logic [NumReq-1:0]            gnt_o, r_valid_o;
    logic [BW-1:0]                r_rdata_o, host_addr_o, host_wdata_o, host_r_rdata;
    logic [BW/8-1:0]              host_be_o;
    logic                         r_err_o, host_req_o, host_we_o, timeout_o;
    logic                         host_gnt, host_r_valid, host_r_err;

    typedef struct {
        int unsigned   idx;
        logic [BW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;

    always #5 clk = ~clk;

    dm_sba_arb #(.NumReq(NumReq), .BusWidth(BW), .TimeoutCycles(TC)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
        .host_req_o(host_req_o), .host_addr_o(host_addr_o), .host_we_o(host_we_o),
        .host_wdata_o(host_wdata_o), .host_be_o(host_be_o), .host_gnt_i(host_gnt),
        .host_r_valid_i(host_r_valid), .host_r_rdata_i(host_r_rdata), .host_r_err_i(host_r_err),
        .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int unsigned idx, input logic [BW-1:0] d, input logic err);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Grant in the current IDLE cycle, answer in the first RESP cycle.
    task automatic serve(input int unsigned idx, input logic [BW-1:0] d, input logic err);
        host_gnt = 1'b1;
        #2;
        chk("serve_gnt", 64'(gnt_o), 64'(1) << idx);
        chk("serve_addr", 64'(host_addr_o), 64'(addr[idx]));
        push_exp(idx, d, err);
        tick();
        host_gnt     = 1'b0;
        host_r_valid = 1'b1;
        host_r_rdata = d;
        host_r_err   = err;
        #2;
        chk("serve_resp_noreq", 64'(host_req_o), 64'd0);
        chk("serve_rvalid", 64'(r_valid_o), 64'(1) << idx);
        tick();
        host_r_valid = 1'b0;
        host_r_err   = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (r_valid_o !== '0)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rvalid", 64'(r_valid_o), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_route", 64'(r_valid_o), 64'(1) << e.idx);
                    chk("sb_rdata", 64'(r_rdata_o), 64'(e.data));
                    chk("sb_err", 64'(r_err_o), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        host_gnt = 1'b0; host_r_valid = 1'b0; host_r_rdata = '0; host_r_err = 1'b0;
        tick();
        tick();
        #2;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_rvalid", 64'(r_valid_o), 64'd0);
        chk("rst_host_req", 64'(host_req_o), 64'd0);
        chk("rst_rdata", 64'(r_rdata_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        chk("rst_ptr", 64'(dut.ptr_q), 64'd0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Basic read
        req = 2'b01; addr[0] = 32'h1000_0000; host_gnt = 1'b1;
        #2;
        chk("basic_gnt", 64'(gnt_o), 64'h1);
        chk("basic_host_req", 64'(host_req_o), 64'h1);
        chk("basic_host_addr", 64'(host_addr_o), 64'h1000_0000);
        push_exp(0, 32'hDEAD_BEEF, 1'b0);
        tick();
        req = '0; host_gnt = 1'b0;
        tick();
        tick();
        host_r_valid = 1'b1; host_r_rdata = 32'hDEAD_BEEF;
        #2;
        chk("basic_rvalid", 64'(r_valid_o), 64'h1);
        chk("basic_rdata", 64'(r_rdata_o), 64'hDEAD_BEEF);
        tick();
        host_r_valid = 1'b0;
        #2;
        chk("basic_ptr", 64'(dut.ptr_q), 64'd1);
        chk("basic_rdata_idle", 64'(r_rdata_o), 64'd0);

        // Reset while waiting for the response
        req = 2'b10; addr[1] = 32'h2000_0004; host_gnt = 1'b1;
        #2;
        chk("rstmid_gnt", 64'(gnt_o), 64'h2);
        tick();
        req = '0; host_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; host_r_valid = 1'b1; host_r_rdata = 32'h5555_AAAA;
        #2;
        chk("rstmid_rvalid", 64'(r_valid_o), 64'd0);
        chk("rstmid_rdata", 64'(r_rdata_o), 64'd0);
        chk("rstmid_ptr", 64'(dut.ptr_q), 64'd0);
        tick();
        host_r_valid = 1'b0;

        // Contention: both requesting, strict rotation from pointer 0
        req = 2'b11; addr[0] = 32'hA000_0000; addr[1] = 32'hB000_0000;
        #2;
        chk("cont_host_req", 64'(host_req_o), 64'h1);
        chk("cont_first_addr", 64'(host_addr_o), 64'hA000_0000);
        chk("cont_no_gnt", 64'(gnt_o), 64'd0);
        tick();
        serve(0, 32'h0000_0A01, 1'b0);
        serve(1, 32'h0000_0B01, 1'b1);
        serve(0, 32'h0000_0A02, 1'b0);
        serve(1, 32'h0000_0B02, 1'b0);
        chk("cont_ptr", 64'(dut.ptr_q), 64'd0);

        // Grant stall with a write from requester 0
        req = 2'b01; we = 2'b01; addr[0] = 32'hC000_0010; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) req = 2'b11;
            #2;
            chk("stall_addr", 64'(host_addr_o), 64'hC000_0010);
            chk("stall_gnt", 64'(gnt_o), 64'd0);
            tick();
        end
        host_gnt = 1'b1;
        #2;
        chk("stall_gnt0", 64'(gnt_o), 64'h1);
        chk("stall_we", 64'(host_we_o), 64'h1);
        chk("stall_wdata", 64'(host_wdata_o), 64'h1234_5678);
        chk("stall_be", 64'(host_be_o), 64'hF);
        push_exp(0, 32'h0, 1'b0);
        tick();
        host_gnt = 1'b0; req = 2'b10;
        #2;
        chk("stall_resp_gnt", 64'(gnt_o), 64'd0);
        chk("stall_resp_host_req", 64'(host_req_o), 64'd0);
        tick();
        host_r_valid = 1'b1; host_r_rdata = 32'h0;
        tick();
        host_r_valid = 1'b0; we = '0;
        serve(1, 32'h0000_0C01, 1'b0);
        req = '0;

`ifdef DM_SBA_ARB_TIMEOUT_EN
        // Response exactly in the limit cycle is a normal response
        req = 2'b01; host_gnt = 1'b1;
        push_exp(0, 32'hB0B0_0001, 1'b1);
        tick();
        req = '0; host_gnt = 1'b0;
        for (int k = 0; k < TC - 1; k++) tick();
        host_r_valid = 1'b1; host_r_rdata = 32'hB0B0_0001; host_r_err = 1'b1;
        #2;
        chk("bound_rvalid", 64'(r_valid_o), 64'h1);
        chk("bound_rdata", 64'(r_rdata_o), 64'hB0B0_0001);
        chk("bound_timeout", 64'(timeout_o), 64'd0);
        tick();
        host_r_valid = 1'b0; host_r_err = 1'b0;
        #2;
        chk("bound_timeout_after", 64'(timeout_o), 64'd0);

        // No response: watchdog abort in the TC-th RESP cycle
        req = 2'b01; host_gnt = 1'b1;
        push_exp(0, 32'h0, 1'b1);
        tick();
        req = '0; host_gnt = 1'b0;
        for (int k = 0; k < TC - 1; k++) begin
            #2;
            chk("to_wait_rvalid", 64'(r_valid_o), 64'd0);
            tick();
        end
        #2;
        chk("to_abort_rvalid", 64'(r_valid_o), 64'h1);
        chk("to_abort_err", 64'(r_err_o), 64'h1);
        chk("to_abort_rdata", 64'(r_rdata_o), 64'd0);
        tick();
        req = 2'b10; host_gnt = 1'b1;
        #2;
        chk("to_flag", 64'(timeout_o), 64'h1);
        chk("to_blocked_gnt", 64'(gnt_o), 64'd0);
        chk("to_blocked_req", 64'(host_req_o), 64'd0);
        tick();
        host_r_valid = 1'b1; host_r_rdata = 32'hBAD0_BAD0;
        #2;
        chk("to_late_dropped", 64'(r_valid_o), 64'd0);
        chk("to_still_blocked", 64'(gnt_o), 64'd0);
        tick();
        host_r_valid = 1'b0;
        serve(1, 32'h0000_0D01, 1'b0);
        chk("to_flag_sticky", 64'(timeout_o), 64'h1);
        req = '0;
`else
        // Without the watchdog a silent target is waited on indefinitely
        req = 2'b01; host_gnt = 1'b1;
        push_exp(0, 32'h0000_0E01, 1'b0);
        tick();
        req = '0; host_gnt = 1'b0;
        for (int k = 0; k < 3 * TC; k++) tick();
        #2;
        chk("nowd_rvalid", 64'(r_valid_o), 64'd0);
        chk("nowd_timeout", 64'(timeout_o), 64'd0);
        tick();
        host_r_valid = 1'b1; host_r_rdata = 32'h0000_0E01;
        #2;
        chk("nowd_late_rvalid", 64'(r_valid_o), 64'h1);
        tick();
        host_r_valid = 1'b0;
`endif

        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_sba_arb.md
# dm_sba_arb

Round-robin arbiter that shares the single system-bus host port (req/gnt/r_valid master interface feeding `tlul_host_adapter` with one outstanding request) between `NumReq` bus requesters. Requester 0 is the debug module's system bus access unit; the others are additional masters such as a debug-trace DMA. The block allows exactly one transaction in flight and routes each response back to the requester that issued it. An optional watchdog completes a stuck transaction with an error.

## Interface
- `NumReq`, default 2: number of requesters; must be at least 2.
- `BusWidth`, default 32: address and data width.
- `TimeoutCycles`, default 1024: watchdog limit in cycles, counted in RESP. Used only when `DM_SBA_ARB_TIMEOUT_EN` is defined. Must be at least 2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; **one clock; reset is synchronous and active-high**.
- `req_i` in [NumReq]: per-requester request. Held with its payload until granted.
- `addr_i` in [NumReq][BusWidth]: per-requester address.
- `we_i` in [NumReq]: per-requester write enable.
- `wdata_i` in [NumReq][BusWidth]: per-requester write data.
- `be_i` in [NumReq][BusWidth/8]: per-requester byte enables.
- `gnt_o` out [NumReq]: grant to the requester.
- `r_valid_o` out [NumReq]: response valid, one-hot.
- `r_rdata_o` out BusWidth: response data, shared by all requesters.
- `r_err_o` out 1: response error, qualified by `r_valid_o`.
- `host_req_o`, `host_addr_o`, `host_we_o`, `host_wdata_o`, `host_be_o` out: downstream request, muxed from the current owner.
- `host_gnt_i`, `host_r_valid_i`, `host_r_rdata_i`, `host_r_err_i` in: downstream grant and response.
- `timeout_o` out 1: sticky flag, set on a watchdog abort and cleared only by reset. Tied to 0 when the macro is undefined.

## Operation
- States:
  - IDLE: arbitrate.
  - REQ: owner locked, request presented, waiting for `host_gnt_i`.
  - RESP: waiting for `host_r_valid_i`.
- Arbitration (IDLE only):
  - The winner is the first asserted `req_i` at or after the round-robin pointer `ptr_q`, searching upward and wrapping modulo NumReq.
  - The winner is forwarded combinationally to `host_*` in the same cycle.
- Grant:
  - `gnt_o[owner] = host_gnt_i` while the owner is presented (IDLE winner or REQ owner). All other `gnt_o` bits are 0.
  - If there is no grant in the arbitration cycle, latch `owner_q` and go to REQ. The owner stays fixed until granted; other requests cannot preempt it.
  - On grant (from IDLE or REQ): go to RESP and set `ptr_q <= (owner+1) % NumReq`.
- Response (RESP):
  - `host_r_valid_i` drives `r_valid_o[owner_q]` in the same cycle, with `host_r_rdata_i`/`host_r_err_i` passed through. Then go to IDLE.
  - `host_req_o` = 0 in RESP.
- No requests pending in IDLE: `host_req_o` = 0, `ptr_q` unchanged.
- `host_r_valid_i` outside RESP (e.g. a response belonging to a transaction from before reset) is dropped: no `r_valid_o`.
- A requester dropping `req_i` before its grant is a protocol violation; the behaviour is undefined, and an assertion covers it.

## Timing
- Request path latency is zero cycles: combinational requester-to-host mux and host-to-requester grant.
- Response path latency is zero cycles.
- The next arbitration happens at the earliest in the cycle after a response, so there is at least 1 IDLE cycle between transactions.
- Simultaneous requests from all requesters are served in strict rotation, one transaction each.
- Reset values:
  - state = IDLE, `ptr_q` = 0, `owner_q` = 0, watchdog count = 0.
  - `timeout_o` = 0 and the stale flag = 0.
  - All `gnt_o`, `r_valid_o`, `host_req_o` = 0; `r_rdata_o` = 0 when no response is valid.
- Reset in REQ or RESP aborts silently: no response is delivered to the owner.

## Configuration
- `DM_SBA_ARB_TIMEOUT_EN` defined:
  - The counter increments each RESP cycle.
  - If the count reaches TimeoutCycles-1 without `host_r_valid_i`, the block issues `r_valid_o[owner_q]` = 1 with `r_err_o` = 1 and `r_rdata_o` = 0, sets `timeout_o` and the stale flag, and goes to IDLE.
  - While the stale flag is set, arbitration is blocked and `host_req_o` = 0.
  - The next `host_r_valid_i` is dropped and clears the stale flag.
  - A real response arriving in the same cycle as the limit takes precedence: the response is normal, with no abort.
- Undefined: no counter, `timeout_o` = 0, and RESP waits indefinitely.

## Test plan
- Basic read: `req_i`=01, `addr_i[0]`=0x1000_0000, `host_gnt_i` high in the same cycle, `host_r_valid_i` 3 cycles later with data 0xDEAD_BEEF → `gnt_o`=01 in cycle 0, `r_valid_o`=01 and `r_rdata_o`=0xDEAD_BEEF in cycle 3, `ptr_q`=1.
- Contention: `req_i`=11 held continuously, each transaction answered after 1 cycle → grants alternate 0,1,0,1, with each response routed only to its owner.
- Grant stall: `req_i`=01 with `host_gnt_i` low for 4 cycles, and `req_i[1]` rising in cycle 1 → `host_addr_o` stays `addr_i[0]`; `gnt_o[1]` is never asserted before requester 0 completes.
- Reset mid-RESP: assert `rst_i` for 1 cycle, then `host_r_valid_i` arrives → no `r_valid_o`, state IDLE, `ptr_q`=0.
- Timeout (macro on, TimeoutCycles=8): grant with no response → `r_valid_o[owner]`=1, `r_err_o`=1 after 8 RESP cycles and `timeout_o`=1; a new `req_i` is not granted until a late `host_r_valid_i` is dropped.
- Timeout boundary: response arrives exactly in cycle TimeoutCycles-1 → normal response, `r_err_o`=`host_r_err_i`, `timeout_o` stays 0.
